contador_palabras: RTL and testbench
====================================

Name: contador_palabras

Overview:
- Responder side of the word-count readout interface (req/idx -> data/valid) of the transaction layer.
- Keeps one counter per output FIFO and counts words actually popped from each one.
- When the layer FSM reports idle, returns the count for the FIFO selected by idx, one cycle after req.
- Sits beside the output FIFOs. It observes their pop/empty signals and the FSM idle/init signals.

Parameters:
- NUM_OUT, 4, number of output FIFOs / counters.
- CNT_WIDTH, 5, width of each counter and of data.
- IDX_WIDTH, 2, width of idx; must equal $clog2(NUM_OUT).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset_L  input  1  asynchronous, active-low reset.
- init  input  1  FSM init; synchronous clear of all counters while high.
- idle  input  1  FSM idle; reads are honoured only while high.
- pop_FIFO_out  input  NUM_OUT  pop strobe per output FIFO (bit i = FIFO out i).
- FIFO_out_empty  input  NUM_OUT  empty flag per output FIFO.
- req  input  1  read request.
- idx  input  IDX_WIDTH  counter selected for the read.
- data  output  CNT_WIDTH  count returned for the read.
- valid  output  1  data is a valid read response.

Behaviour:
Reset
- reset_L low, asynchronous: all counters = 0, data = 0, valid = 0.
- This holds immediately, even mid-read or mid-count.

Counting
- At each posedge, counter i increments when pop_FIFO_out[i] && !FIFO_out_empty[i].
- A pop while the FIFO is empty does not count.
- Counters saturate at 2^CNT_WIDTH-1 (31); they never wrap.
- Counters are cumulative across reads. A read does not clear them.

Clear
- init high at a posedge: all counters = 0 at that edge.
- init has priority over a simultaneous pop, so a pop in that cycle is lost.
- data/valid are unaffected by init, except that a read in the same cycle returns the pre-clear value.

Read handshake
- At a posedge with req && idle: data <= counter[idx] (value before any same-edge increment) and valid <= 1.
- Latency is one cycle: the response is visible during the cycle after req is sampled.
- At a posedge with !(req && idle): valid <= 0 and data <= 0.
- A request while idle is low is dropped. It is not queued, and no response follows.
- req held high: one response per cycle. data follows the idx sampled on the previous edge, so an idx change appears one cycle later.
- idx outside 0..NUM_OUT-1 (only possible if NUM_OUT is not a power of 2): data = 0, valid = 1.

State
- Two-state read FSM:
  - WAIT: valid = 0. Moves to RESP on req && idle.
  - RESP: valid = 1. Stays in RESP on req && idle; otherwise returns to WAIT.
- Registered outputs only; no combinational path from inputs to data/valid.

Decomposition:
- Shared package: NUM_OUT, CNT_WIDTH, IDX_WIDTH, and the read-FSM state encoding (WAIT = 0, RESP = 1).
- One natural sub-module, contador_sat: a single saturating counter with inc, clr and async reset_L, instantiated NUM_OUT times.
- Top level holds the enable qualification, the idx mux and the read FSM.

Test Plan:
- 5 pops, no reads: 5 valid pops (empty=0) on each FIFO, then idle=1, req=1, idx=0..3, each held 3 cycles -> data=5 and valid=1, one cycle after each sample.
- Read while busy: req=1 with idle=0 for 4 cycles -> valid=0 and data=0 throughout; raising idle with req still high -> valid=1 on the next cycle.
- Pop on empty: 3 pops on FIFO out 2 with empty=1, then 2 pops with empty=0 -> read idx=2 returns 2.
- Saturation and clear: 40 valid pops on FIFO out 1 -> read returns 31. Then init=1 for one cycle plus a simultaneous pop -> read returns 0.
- Cumulative reads: read idx=3 returns 6; then 4 more pops on FIFO out 3; second read returns 10.
- Reset mid-read: reset_L=0 while valid=1 -> data=0 and valid=0 immediately (asynchronous); after release, all counters read 0.

Source files
------------

// File: rtl/contador_palabras_pkg.sv
// Shared sizing constants and read-FSM encoding for the word-count readout block.
package contador_palabras_pkg;

    localparam int CP_NUM_OUT   = 4;
    localparam int CP_CNT_WIDTH = 5;
    localparam int CP_IDX_WIDTH = 2;

    typedef enum logic {
        WAIT = 1'b0,
        RESP = 1'b1
    } rd_state_e;

endpackage

// File: rtl/contador_palabras_sat.sv
// Single saturating word counter: synchronous clear beats increment, holds at all-ones.
module contador_sat #(
    parameter int CNT_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic                 inc,
    input  logic                 clr,
    output logic [CNT_WIDTH-1:0] cnt
);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/contador_palabras.sv
// Per-FIFO popped-word counters with a one-cycle registered readout, honoured only while idle.
module contador_palabras
    import contador_palabras_pkg::*;
#(
    parameter int NUM_OUT   = CP_NUM_OUT,
    parameter int CNT_WIDTH = CP_CNT_WIDTH,
    parameter int IDX_WIDTH = CP_IDX_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic                 init,
    input  logic                 idle,
    input  logic [NUM_OUT-1:0]   pop_FIFO_out,
    input  logic [NUM_OUT-1:0]   FIFO_out_empty,
    input  logic                 req,
    input  logic [IDX_WIDTH-1:0] idx,
    output logic [CNT_WIDTH-1:0] data,
    output logic                 valid
);

    logic [NUM_OUT-1:0]                inc;
    logic [NUM_OUT-1:0][CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0]              sel;
    logic                              rd_go;

    rd_state_e            state_q, state_d;
    logic [CNT_WIDTH-1:0] data_q, data_d;

    // A pop against an empty FIFO moves no word, so it is not counted.
    assign inc = pop_FIFO_out & ~FIFO_out_empty;

    generate
        for (genvar g = 0; g < NUM_OUT; g++) begin : g_cnt
            contador_sat #(
                .CNT_WIDTH(CNT_WIDTH)
            ) u_cnt (
                .clk    (clk),
                .reset_L(reset_L),
                .inc    (inc[g]),
                .clr    (init),
                .cnt    (cnt[g])
            );
        end
    endgenerate

    // Unmatched idx values fall through to zero.
    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (idx == IDX_WIDTH'(i)) begin
                sel = cnt[i];
            end
        end
    end

    assign rd_go = req && idle;

    always_comb begin
        state_d = WAIT;
        data_d  = '0;
        case (state_q)
            WAIT: begin
                if (rd_go) begin
                    state_d = RESP;
                    data_d  = sel;
                end
            end
            RESP: begin
                if (rd_go) begin
                    state_d = RESP;
                    data_d  = sel;
                end
            end
            default: begin
                state_d = WAIT;
                data_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= WAIT;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign data  = data_q;
    assign valid = (state_q == RESP);

endmodule

// File: tb/tb_contador_palabras.sv
// Directed table-driven bench for contador_palabras plus hand-written reset corner cases.
module tb_contador_palabras;

    logic       clk;
    logic       reset_L;
    logic       init;
    logic       idle;
    logic [3:0] pop_FIFO_out;
    logic [3:0] FIFO_out_empty;
    logic       req;
    logic [1:0] idx;
    logic [4:0] data;
    logic       valid;

    int n_cmp = 0;
    int n_err = 0;

    contador_palabras dut (
        .clk           (clk),
        .reset_L       (reset_L),
        .init          (init),
        .idle          (idle),
        .pop_FIFO_out  (pop_FIFO_out),
        .FIFO_out_empty(FIFO_out_empty),
        .req           (req),
        .idx           (idx),
        .data          (data),
        .valid         (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One row = inputs held for one cycle + outputs expected just after that edge.
    typedef struct {
        string      tag;
        logic       init;
        logic       idle;
        logic [3:0] pop;
        logic [3:0] empty;
        logic       req;
        logic [1:0] idx;
        logic [4:0] exp_data;
        logic       exp_valid;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input string tag, input logic i_init, input logic i_idle,
                                input logic [3:0] i_pop, input logic [3:0] i_empty,
                                input logic i_req, input logic [1:0] i_idx,
                                input logic [4:0] e_data, input logic e_valid);
        vec_t v;
        v.tag = tag; v.init = i_init; v.idle = i_idle; v.pop = i_pop; v.empty = i_empty;
        v.req = i_req; v.idx = i_idx; v.exp_data = e_data; v.exp_valid = e_valid;
        tbl.push_back(v);
    endfunction

    task automatic check(input string tag, input logic [4:0] e_data, input logic e_valid);
        n_cmp++;
        if (data !== e_data || valid !== e_valid) begin
            n_err++;
            $display("FAIL %s: got data=%0d valid=%0b, want data=%0d valid=%0b",
                     tag, data, valid, e_data, e_valid);
        end
    endtask

    initial begin
        reset_L = 1'b0; init = 1'b0; idle = 1'b0; pop_FIFO_out = '0;
        FIFO_out_empty = '0; req = 1'b0; idx = '0;

        // 5 valid pops on every FIFO, then read each counter for 3 cycles
        for (int i = 0; i < 5; i++) add("pop5", 0, 0, 4'hF, 4'h0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++)
            for (int r = 0; r < 3; r++) add("read5", 0, 1, 4'h0, 4'h0, 1, 2'(k), 5, 1);
        add("drop", 0, 1, 4'h0, 4'h0, 0, 0, 0, 0);
        // request while busy is dropped, then honoured once idle rises
        for (int i = 0; i < 4; i++) add("busy", 0, 0, 4'h0, 4'h0, 1, 1, 0, 0);
        add("busy_go", 0, 1, 4'h0, 4'h0, 1, 1, 5, 1);
        add("busy_end", 0, 1, 4'h0, 4'h0, 0, 1, 0, 0);
        // pops on an empty FIFO are ignored
        add("clr1", 1, 0, 4'h0, 4'h0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) add("pop_empty", 0, 0, 4'b0100, 4'b0100, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) add("pop_ok", 0, 0, 4'b0100, 4'b0000, 0, 0, 0, 0);
        add("read_f2", 0, 1, 4'h0, 4'h0, 1, 2, 2, 1);
        add("read_f0", 0, 1, 4'h0, 4'h0, 1, 0, 0, 1);
        // saturation, then init beats a same-cycle pop but the read sees the old value
        add("clr2", 1, 0, 4'h0, 4'h0, 0, 0, 0, 0);
        for (int i = 0; i < 40; i++) add("pop40", 0, 0, 4'b0010, 4'b0000, 0, 0, 0, 0);
        add("read_sat", 0, 1, 4'h0, 4'h0, 1, 1, 31, 1);
        add("init_rd", 1, 1, 4'b0010, 4'b0000, 1, 1, 31, 1);
        add("read_clr", 0, 1, 4'h0, 4'h0, 1, 1, 0, 1);
        add("idle_end", 0, 1, 4'h0, 4'h0, 0, 0, 0, 0);
        // cumulative reads; a same-edge pop is not seen by that read
        for (int i = 0; i < 6; i++) add("pop6", 0, 0, 4'b1000, 4'b0000, 0, 0, 0, 0);
        add("read_6", 0, 1, 4'h0, 4'h0, 1, 3, 6, 1);
        add("gap", 0, 1, 4'h0, 4'h0, 0, 3, 0, 0);
        for (int i = 0; i < 4; i++) add("pop4", 0, 0, 4'b1000, 4'b0000, 0, 0, 0, 0);
        add("read_10", 0, 1, 4'h0, 4'h0, 1, 3, 10, 1);
        add("rd_pop", 0, 1, 4'b1000, 4'b0000, 1, 3, 10, 1);
        add("read_11", 0, 1, 4'h0, 4'h0, 1, 3, 11, 1);
        add("idx_chg", 0, 1, 4'h0, 4'h0, 1, 1, 0, 1);
        add("idx_back", 0, 1, 4'h0, 4'h0, 1, 3, 11, 1);
        // mixed pop/empty pattern: only FIFOs 1 and 3 advance
        add("mix", 0, 0, 4'b1111, 4'b0101, 0, 0, 0, 0);
        add("mix_r0", 0, 1, 4'h0, 4'h0, 1, 0, 0, 1);
        add("mix_r1", 0, 1, 4'h0, 4'h0, 1, 1, 1, 1);
        add("mix_r3", 0, 1, 4'h0, 4'h0, 1, 3, 12, 1);
        add("quiet", 0, 1, 4'h0, 4'h0, 0, 0, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        check("reset", 5'd0, 1'b0);
        reset_L = 1'b1;

        foreach (tbl[n]) begin
            init = tbl[n].init; idle = tbl[n].idle; pop_FIFO_out = tbl[n].pop;
            FIFO_out_empty = tbl[n].empty; req = tbl[n].req; idx = tbl[n].idx;
            @(posedge clk);
            #1;
            check(tbl[n].tag, tbl[n].exp_data, tbl[n].exp_valid);
        end

        // asynchronous reset in the middle of an active response
        idle = 1'b1; req = 1'b1; idx = 2'd3; pop_FIFO_out = '0; FIFO_out_empty = '0; init = 1'b0;
        @(posedge clk);
        #1;
        check("pre_rst", 5'd12, 1'b1);
        #2;
        reset_L = 1'b0;
        #1;
        check("async_rst", 5'd0, 1'b0);
        @(posedge clk);
        #1;
        check("rst_hold", 5'd0, 1'b0);
        reset_L = 1'b1;
        for (int k = 0; k < 4; k++) begin
            idx = 2'(k);
            @(posedge clk);
            #1;
            check("post_rst", 5'd0, 1'b1);
        end
        req = 1'b0;
        @(posedge clk);
        #1;
        check("final_idle", 5'd0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
